// File: rtl/control_unit_pkg.sv
// Shared types for the control_unit sequencer: opcodes, state encodings,
// jump conditions, the strobe bundle and the wait-counter width helper.
package control_unit_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ALU_RR = 4'h1,
    OP_ALU_RI = 4'h2,
    OP_LOADI  = 4'h3,
    OP_LOAD   = 4'h4,
    OP_STORE  = 4'h5,
    OP_JUMP   = 4'h6,
    OP_HALT   = 4'h7,
    OP_SPADJ  = 4'h8
  } opcode_t;

  typedef enum logic [3:0] {
    ST_BOOT      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EXEC      = 4'd3,
    ST_LOAD_WAIT = 4'd4,
    ST_HALT      = 4'd5,
    ST_FAULT     = 4'd6,
    ST_STEP_HOLD = 4'd7
  } state_t;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_NZ     = 2'b10;
  localparam logic [1:0] COND_NEVER  = 2'b11;

  typedef struct packed {
    logic fetch_instruction;
    logic reg_write;
    logic mem_to_reg;
    logic alu_override_imm8;
    logic alu_override_imm4;
    logic alu_set_flags;
    logic set_pc;
    logic pc_from_register;
    logic mem_write;
    logic set_sp;
    logic increase_sp;
  } strobes_t;

  // Counter must hold values up to wait_limit - 1 with headroom for compare.
  function automatic int wait_cnt_width(input int wait_limit);
    return (wait_limit < 2) ? 1 : $clog2(wait_limit + 1);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Datapath-facing bundle of the control_unit: instruction/flag/memory inputs
// toward the sequencer (master) and control strobes back to the datapath.
interface control_unit_if;
  logic [15:0] current_instruction;
  logic        Z_out;
  logic        mem_rvalid;
  logic        fetch_instruction;
  logic        reg_write;
  logic        mem_to_reg;
  logic        alu_override_imm8;
  logic        alu_override_imm4;
  logic        alu_set_flags;
  logic        set_pc;
  logic        pc_from_register;
  logic        mem_write;
  logic        set_sp;
  logic        increase_sp;
  logic        halted;
  logic        fault;
  logic [3:0]  state_poke;

  modport master (
    input  current_instruction, Z_out, mem_rvalid,
    output fetch_instruction, reg_write, mem_to_reg, alu_override_imm8,
           alu_override_imm4, alu_set_flags, set_pc, pc_from_register,
           mem_write, set_sp, increase_sp, halted, fault, state_poke
  );

  modport slave (
    output current_instruction, Z_out, mem_rvalid,
    input  fetch_instruction, reg_write, mem_to_reg, alu_override_imm8,
           alu_override_imm4, alu_set_flags, set_pc, pc_from_register,
           mem_write, set_sp, increase_sp, halted, fault, state_poke
  );
endinterface

// File: rtl/control_unit_decode.sv
// Combinational EXEC-cycle strobe table keyed by opcode and jump condition.
// cond[0] doubles as the SP direction bit for SP adjust.
module control_decode
  import control_unit_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [1:0] cond,
  input  logic       z_flag,
  output strobes_t   exec_strobes
);

  logic jump_taken;

  always_comb begin
    jump_taken = 1'b0;
    unique case (cond)
      COND_ALWAYS: jump_taken = 1'b1;
      COND_Z:      jump_taken = z_flag;
      COND_NZ:     jump_taken = ~z_flag;
      COND_NEVER:  jump_taken = 1'b0;
      default:     jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    exec_strobes = '0;
    case (opcode_t'(opcode))
      OP_ALU_RR: begin
        exec_strobes.reg_write     = 1'b1;
        exec_strobes.alu_set_flags = 1'b1;
      end
      OP_ALU_RI: begin
        exec_strobes.reg_write         = 1'b1;
        exec_strobes.alu_set_flags     = 1'b1;
        exec_strobes.alu_override_imm4 = 1'b1;
      end
      OP_LOADI: begin
        exec_strobes.reg_write         = 1'b1;
        exec_strobes.alu_override_imm8 = 1'b1;
      end
      OP_STORE: exec_strobes.mem_write = 1'b1;
      OP_JUMP: begin
        exec_strobes.set_pc           = jump_taken;
        exec_strobes.pc_from_register = jump_taken;
      end
      OP_SPADJ: begin
        exec_strobes.set_sp      = 1'b1;
        exec_strobes.increase_sp = cond[0];
      end
      default: exec_strobes = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer driving the datapath control strobes.
// Optional single-step hold is enabled with CONTROL_STEP_EN.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
`ifdef CONTROL_STEP_EN
  input  logic step_mode,
  input  logic step_go,
`endif
  control_unit_if.master bus
);

  localparam int WAIT_CNT_W = wait_cnt_width(WAIT_LIMIT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_LIMIT - 1);

  state_t                state, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next;
  strobes_t              strobes, exec_strobes;
  state_t                fetch_target;
  logic                  step_rise;
  logic                  unused_instr_bits;

  assign unused_instr_bits = ^bus.current_instruction[11:2];

`ifdef CONTROL_STEP_EN
  logic step_go_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) step_go_q <= 1'b0;
    else       step_go_q <= step_go;
  end

  assign step_rise    = step_go & ~step_go_q;
  assign fetch_target = step_mode ? ST_STEP_HOLD : ST_FETCH;
`else
  assign step_rise    = 1'b1;
  assign fetch_target = ST_FETCH;
`endif

  control_decode u_decode (
    .opcode       (bus.current_instruction[15:12]),
    .cond         (bus.current_instruction[1:0]),
    .z_flag       (bus.Z_out),
    .exec_strobes (exec_strobes)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_BOOT;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // wait_cnt only survives while stalled in FETCH/LOAD_WAIT; any exit clears it.
  always_comb begin
    state_next    = state;
    wait_cnt_next = '0;
    strobes       = '0;
    unique case (state)
      ST_BOOT: state_next = fetch_target;
      ST_FETCH: begin
        strobes.fetch_instruction = 1'b1;
        if (bus.mem_rvalid) begin
          strobes.set_pc = 1'b1;
          state_next     = ST_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = ST_FAULT;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        strobes = exec_strobes;
        case (opcode_t'(bus.current_instruction[15:12]))
          OP_LOAD: state_next = ST_LOAD_WAIT;
          OP_HALT: state_next = ST_HALT;
          default: state_next = fetch_target;
        endcase
      end
      ST_LOAD_WAIT: begin
        strobes.mem_to_reg = 1'b1;
        if (bus.mem_rvalid) begin
          strobes.reg_write = 1'b1;
          state_next        = fetch_target;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = ST_FAULT;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      ST_HALT:  state_next = ST_HALT;
      ST_FAULT: state_next = ST_FAULT;
      ST_STEP_HOLD: if (step_rise) state_next = ST_FETCH;
      default:  state_next = ST_BOOT;
    endcase
  end

  assign bus.fetch_instruction = strobes.fetch_instruction;
  assign bus.reg_write         = strobes.reg_write;
  assign bus.mem_to_reg        = strobes.mem_to_reg;
  assign bus.alu_override_imm8 = strobes.alu_override_imm8;
  assign bus.alu_override_imm4 = strobes.alu_override_imm4;
  assign bus.alu_set_flags     = strobes.alu_set_flags;
  assign bus.set_pc            = strobes.set_pc;
  assign bus.pc_from_register  = strobes.pc_from_register;
  assign bus.mem_write         = strobes.mem_write;
  assign bus.set_sp            = strobes.set_sp;
  assign bus.increase_sp       = strobes.increase_sp;
  assign bus.halted            = (state == ST_HALT);
  assign bus.fault             = (state == ST_FAULT);
  assign bus.state_poke        = state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus randomized
// instruction streams checked against a transaction-level expectation model.
module tb_control_unit;

  localparam int WL = 4;

  localparam logic [10:0] B_FETCH = 11'h400;
  localparam logic [10:0] B_RW    = 11'h200;
  localparam logic [10:0] B_M2R   = 11'h100;
  localparam logic [10:0] B_I8    = 11'h080;
  localparam logic [10:0] B_I4    = 11'h040;
  localparam logic [10:0] B_FL    = 11'h020;
  localparam logic [10:0] B_SPC   = 11'h010;
  localparam logic [10:0] B_PCR   = 11'h008;
  localparam logic [10:0] B_MW    = 11'h004;
  localparam logic [10:0] B_SSP   = 11'h002;
  localparam logic [10:0] B_ISP   = 11'h001;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   idle_state = 1;
  logic [10:0] obs;

  control_unit_if bus();

`ifdef CONTROL_STEP_EN
  logic step_mode = 1'b0;
  logic step_go   = 1'b0;
`endif

  control_unit #(.WAIT_LIMIT(WL)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef CONTROL_STEP_EN
    .step_mode (step_mode),
    .step_go   (step_go),
`endif
    .bus       (bus)
  );

  always #5 clock = ~clock;

  assign obs = {bus.fetch_instruction, bus.reg_write, bus.mem_to_reg,
                bus.alu_override_imm8, bus.alu_override_imm4, bus.alu_set_flags,
                bus.set_pc, bus.pc_from_register, bus.mem_write, bus.set_sp,
                bus.increase_sp};

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Expected EXEC-cycle strobes straight from the opcode table.
  function automatic logic [10:0] exp_exec(input logic [15:0] instr, input logic z);
    logic [3:0] op;
    int c;
    bit taken;
    op = instr[15:12];
    c  = int'(instr[1:0]);
    taken = (c == 0) || (c == 1 && z) || (c == 2 && !z);
    case (op)
      4'h1: return B_RW | B_FL;
      4'h2: return B_RW | B_FL | B_I4;
      4'h3: return B_RW | B_I8;
      4'h5: return B_MW;
      4'h6: return taken ? (B_SPC | B_PCR) : 11'h000;
      4'h8: return instr[0] ? (B_SSP | B_ISP) : B_SSP;
      default: return 11'h000;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_rvalid = 1'b0;
    #3;
    chk("rst_state", 16'(bus.state_poke), 16'd0);
    chk("rst_strobes", 16'(obs), 16'h0);
    chk("rst_flags", {14'd0, bus.halted, bus.fault}, 16'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("boot_state", 16'(bus.state_poke), 16'd0);
    chk("boot_strobes", 16'(obs), 16'h0);
    tick();
    chk("after_boot", 16'(bus.state_poke), 16'(idle_state));
  endtask

  // One complete instruction starting from FETCH; fd/ld are rvalid delays.
  task automatic do_instr(input logic [15:0] instr, input logic z, input int fd, input int ld);
    for (int i = 0; i < fd; i++) begin
      bus.mem_rvalid = 1'b0;
      #1;
      chk("fetch_wait_state", 16'(bus.state_poke), 16'd1);
      chk("fetch_wait_strobes", 16'(obs), 16'(B_FETCH));
      tick();
    end
    bus.mem_rvalid = 1'b1;
    bus.current_instruction = instr;
    #1;
    chk("fetch_state", 16'(bus.state_poke), 16'd1);
    chk("fetch_strobes", 16'(obs), 16'(B_FETCH | B_SPC));
    tick();
    bus.mem_rvalid = 1'b0;
    bus.Z_out = z;
    #1;
    chk("decode_state", 16'(bus.state_poke), 16'd2);
    chk("decode_strobes", 16'(obs), 16'h0);
    tick();
    #1;
    chk("exec_state", 16'(bus.state_poke), 16'd3);
    chk("exec_strobes", 16'(obs), 16'(exp_exec(instr, z)));
    chk("exec_flags", {14'd0, bus.halted, bus.fault}, 16'h0);
    tick();
    if (instr[15:12] == 4'h4) begin
      for (int i = 0; i < ld; i++) begin
        #1;
        chk("lw_state", 16'(bus.state_poke), 16'd4);
        chk("lw_strobes", 16'(obs), 16'(B_M2R));
        tick();
      end
      bus.mem_rvalid = 1'b1;
      #1;
      chk("lw_done_strobes", 16'(obs), 16'(B_M2R | B_RW));
      tick();
      bus.mem_rvalid = 1'b0;
    end
    #1;
    if (instr[15:12] == 4'h7) begin
      chk("halt_state", 16'(bus.state_poke), 16'd5);
      chk("halt_flag", {15'd0, bus.halted}, 16'd1);
      chk("halt_strobes", 16'(obs), 16'h0);
    end else begin
      chk("next_state", 16'(bus.state_poke), 16'(idle_state));
    end
  endtask

  initial begin
    logic [15:0] instr;
    logic [3:0]  op;
    bus.current_instruction = 16'h0000;
    bus.Z_out = 1'b0;
    bus.mem_rvalid = 1'b0;

    do_reset();
    do_instr(16'h3105, 1'b0, 1, 0);
    do_instr(16'h4120, 1'b0, 0, 3);
    do_instr(16'h6301, 1'b0, 0, 0);
    do_instr(16'h6301, 1'b1, 0, 0);
    do_instr(16'h6302, 1'b0, 2, 0);
    do_instr(16'h6303, 1'b1, 0, 0);
    do_instr(16'h5120, 1'b0, 0, 0);
    do_instr(16'h8001, 1'b0, 0, 0);
    do_instr(16'h8000, 1'b0, 3, 0);
    do_instr(16'h4120, 1'b1, 3, 0);

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h7) op = 4'h0;
      instr = {op, 12'($urandom)};
      do_instr(instr, 1'($urandom_range(0, 1)), $urandom_range(0, WL - 1),
               $urandom_range(0, WL - 1));
    end

    do_instr(16'h7000, 1'b0, 1, 0);
    bus.mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_hold_state", 16'(bus.state_poke), 16'd5);
      chk("halt_hold_strobes", 16'(obs), 16'h0);
    end
    bus.mem_rvalid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("halt_async_state", 16'(bus.state_poke), 16'd0);
    chk("halt_async_flag", {15'd0, bus.halted}, 16'd0);
    do_reset();

    for (int i = 0; i < WL; i++) begin
      #1;
      chk("to_state", 16'(bus.state_poke), 16'd1);
      chk("to_strobes", 16'(obs), 16'(B_FETCH));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      bus.mem_rvalid = 1'(i);
      #1;
      chk("fault_state", 16'(bus.state_poke), 16'd6);
      chk("fault_flag", {14'd0, bus.halted, bus.fault}, 16'd1);
      chk("fault_strobes", 16'(obs), 16'h0);
      tick();
    end
    do_reset();

    bus.mem_rvalid = 1'b1;
    bus.current_instruction = 16'h4120;
    tick();
    bus.mem_rvalid = 1'b0;
    tick();
    tick();
    #1;
    chk("abort_lw_state", 16'(bus.state_poke), 16'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_state", 16'(bus.state_poke), 16'd0);
    chk("abort_strobes", 16'(obs), 16'h0);
    do_reset();
    do_instr(16'h1234, 1'b0, 0, 0);

`ifdef CONTROL_STEP_EN
    step_mode = 1'b1;
    idle_state = 7;
    do_instr(16'h0000, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("step_hold_state", 16'(bus.state_poke), 16'd7);
      chk("step_hold_strobes", 16'(obs), 16'h0);
    end
    step_go = 1'b1;
    tick();
    #1;
    chk("step_go_state", 16'(bus.state_poke), 16'd1);
    do_instr(16'h0000, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("step_once_state", 16'(bus.state_poke), 16'd7);
    end
    step_go = 1'b0;
    step_mode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
